// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback requesters.
// Optional reservation scoreboard enabled by defining REGWR_SCOREBOARD_EN.
module reg_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_num,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wr_stall,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_num,
    output logic [DATA_W-1:0]         wr_data,
`ifdef REGWR_SCOREBOARD_EN
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_num,
    output logic [31:0]               busy,
`endif
    output logic [IDW-1:0]            grant_id
);

    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_num_q, wr_num_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] gnt_s;
    logic [IDW-1:0]     gnt_id_s;
    logic               xfer_s;
    logic [IDW:0]       scan_sum_s;
    logic [IDW-1:0]     scan_idx_s;
    logic [ADDR_W-1:0]  sel_num_s;
    logic [DATA_W-1:0]  sel_data_s;

    // Round-robin scan from rr_ptr; ready is gated by reset and stall so nothing is granted then.
    always_comb begin
        gnt_s      = {NUM_REQ{1'b0}};
        gnt_id_s   = {IDW{1'b0}};
        xfer_s     = 1'b0;
        scan_sum_s = {(IDW+1){1'b0}};
        scan_idx_s = {IDW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_sum_s >= (IDW+1)'(NUM_REQ)) begin
                scan_sum_s = scan_sum_s - (IDW+1)'(NUM_REQ);
            end else begin
                scan_sum_s = scan_sum_s;
            end
            scan_idx_s = scan_sum_s[IDW-1:0];
            if (!xfer_s && req_valid[scan_idx_s] && !wr_stall && rst_n) begin
                xfer_s   = 1'b1;
                gnt_id_s = scan_idx_s;
            end else begin
                xfer_s   = xfer_s;
            end
        end
        if (xfer_s) begin
            gnt_s[gnt_id_s] = 1'b1;
        end else begin
            gnt_s = {NUM_REQ{1'b0}};
        end
    end

    // Select the winning requester's index and data.
    always_comb begin
        sel_num_s  = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_num_s  = req_num[i*ADDR_W +: ADDR_W];
                sel_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                sel_num_s  = sel_num_s;
            end
        end
    end

    // Next state of pointer and output register; x0 writes are consumed without a write strobe.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = 1'b0;
        wr_num_d   = wr_num_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (xfer_s) begin
            if (gnt_id_s == IDW'(NUM_REQ - 1)) begin
                rr_ptr_d = {IDW{1'b0}};
            end else begin
                rr_ptr_d = gnt_id_s + {{(IDW-1){1'b0}}, 1'b1};
            end
            wr_en_d    = (sel_num_s != {ADDR_W{1'b0}});
            wr_num_d   = sel_num_s;
            wr_data_d  = sel_data_s;
            grant_id_d = gnt_id_s;
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Pointer and output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= {IDW{1'b0}};
            wr_en_q    <= 1'b0;
            wr_num_q   <= {ADDR_W{1'b0}};
            wr_data_q  <= {DATA_W{1'b0}};
            grant_id_q <= {IDW{1'b0}};
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_num_q   <= wr_num_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign req_ready = gnt_s;
    assign wr_en     = wr_en_q;
    assign wr_num    = wr_num_q;
    assign wr_data   = wr_data_q;
    assign grant_id  = grant_id_q;

`ifdef REGWR_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // A reservation on the same edge as the retiring write keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < 32; r++) begin
            if (rsv_valid && (rsv_num == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (xfer_s && (sel_num_s == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (NUM_REQ=3, DATA_W=32, ADDR_W=5).
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_num;
    logic [95:0] req_data;
    logic        wr_stall;
    logic        wr_en;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic [1:0]  grant_id;
`ifdef REGWR_SCOREBOARD_EN
    logic        rsv_valid;
    logic [4:0]  rsv_num;
    logic [31:0] busy;
`endif

    int total = 0;
    int bad   = 0;

    reg_write_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_data(req_data),
        .wr_stall(wr_stall),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
`ifdef REGWR_SCOREBOARD_EN
        .rsv_valid(rsv_valid), .rsv_num(rsv_num), .busy(busy),
`endif
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 3'b000;
        req_num   = 15'd0;
        req_data  = 96'd0;
        wr_stall  = 1'b0;
`ifdef REGWR_SCOREBOARD_EN
        rsv_valid = 1'b0;
        rsv_num   = 5'd0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 3'b111;
        #2;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_num !== 5'd0 || wr_data !== 32'd0 || grant_id !== 2'd0) begin
            bad++; $display("FAIL reset_regs got num=%0d data=%h gid=%0d exp 0/0/0", wr_num, wr_data, grant_id);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid       = 3'b001;
        req_num[4:0]    = 5'd7;
        req_data[31:0]  = 32'hDEADBEEF;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", req_ready); end
        tick();
        req_valid = 3'b000;
        total++; if (wr_en !== 1'b1 || wr_num !== 5'd7 || wr_data !== 32'hDEADBEEF || grant_id !== 2'd0) begin
            bad++; $display("FAIL single_write got en=%b num=%0d data=%h gid=%0d exp 1/7/deadbeef/0", wr_en, wr_num, wr_data, grant_id);
        end
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_one_pulse got=%b exp=0", wr_en); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy;
        do_reset();
        req_num  = {5'd3, 5'd2, 5'd1};
        req_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_rdy = 3'b001 << (c % 3);
            #1;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            tick();
            total++; if (wr_en !== 1'b1 || grant_id !== 2'(c % 3) || wr_num !== 5'(c % 3 + 1)) begin
                bad++; $display("FAIL rr_write c=%0d got en=%b gid=%0d num=%0d exp 1/%0d/%0d", c, wr_en, grant_id, wr_num, c % 3, c % 3 + 1);
            end
        end
        req_valid = 3'b000;
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b exp=0", wr_en); end
    endtask

    task automatic test_x0();
        do_reset();
        req_valid       = 3'b010;
        req_num[9:5]    = 5'd0;
        req_data[63:32] = 32'h55;
        #1;
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL x0_ready got=%b exp=010", req_ready); end
        tick();
        total++; if (wr_en !== 1'b0 || grant_id !== 2'd1 || wr_data !== 32'h55) begin
            bad++; $display("FAIL x0_write got en=%b gid=%0d data=%h exp 0/1/55", wr_en, grant_id, wr_data);
        end
        req_valid = 3'b111;
        #1;
        total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL x0_ptr got=%b exp=100", req_ready); end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid    = 3'b001;
        req_num      = {5'd12, 5'd11, 5'd9};
        tick();
        req_valid = 3'b110;
        wr_stall  = 1'b1;
        #1;
        total++; if (wr_en !== 1'b1 || wr_num !== 5'd9) begin bad++; $display("FAIL stall_inflight got en=%b num=%0d exp 1/9", wr_en, wr_num); end
        for (int c = 0; c < 3; c++) begin
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=000", c, req_ready); end
            tick();
            total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL stall_wr_en c=%0d got=%b exp=0", c, wr_en); end
        end
        wr_stall = 1'b0;
        #1;
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL stall_resume got=%b exp=010", req_ready); end
        tick();
        total++; if (wr_en !== 1'b1 || grant_id !== 2'd1 || wr_num !== 5'd11) begin
            bad++; $display("FAIL stall_resume_write got en=%b gid=%0d num=%0d exp 1/1/11", wr_en, grant_id, wr_num);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid    = 3'b001;
        req_num[4:0] = 5'd4;
        tick();
        req_valid = 3'b000;
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", wr_en); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || wr_num !== 5'd0) begin bad++; $display("FAIL mid_async got en=%b num=%0d exp 0/0", wr_en, wr_num); end
        tick();
        rst_n     = 1'b1;
        req_valid = 3'b111;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL mid_restart got=%b exp=001", req_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 3'b100;
        for (int c = 0; c < 3; c++) begin
            req_num[14:10]  = 5'(c + 20);
            req_data[95:64] = 32'h1000 + 32'(c);
            #1;
            total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=100", c, req_ready); end
            tick();
            total++; if (wr_en !== 1'b1 || grant_id !== 2'd2 || wr_num !== 5'(c + 20) || wr_data !== 32'h1000 + 32'(c)) begin
                bad++; $display("FAIL b2b_write c=%0d got en=%b gid=%0d num=%0d data=%h", c, wr_en, grant_id, wr_num, wr_data);
            end
        end
        req_valid = 3'b000;
    endtask

`ifdef REGWR_SCOREBOARD_EN
    task automatic test_scoreboard();
        do_reset();
        rsv_valid = 1'b1;
        rsv_num   = 5'd5;
        tick();
        rsv_valid = 1'b0;
        total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b exp=1", busy[5]); end
        tick();
        req_valid       = 3'b100;
        req_num[14:10]  = 5'd5;
        #1;
        total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL sb_hold got=%b exp=1", busy[5]); end
        tick();
        req_valid = 3'b000;
        total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b exp=0", busy[5]); end
        rsv_valid = 1'b1;
        rsv_num   = 5'd5;
        req_valid = 3'b100;
        tick();
        rsv_valid = 1'b0;
        req_valid = 3'b000;
        total++; if (busy[5] !== 1'b1 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL sb_set_wins got b5=%b b0=%b exp 1/0", busy[5], busy[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_x0();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef REGWR_SCOREBOARD_EN
        test_scoreboard();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single register-file write port (wr_en/wr_num/wr_data) among NUM_REQ writeback requesters, e.g. ALU, load unit and CSR unit.
- Arbitration is round-robin with per-requester valid/ready handshakes.
- The winning request is registered, giving the write port one cycle of latency.
- The block sits between the execute/writeback stages and the register file, and is the only driver of the register-file write port.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width (32 architectural registers, x0 hardwired zero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_ready  out  NUM_REQ  requester i is granted this cycle; combinational.
- req_num  in  NUM_REQ*ADDR_W  destination index, requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  write data, requester i at bits [i*DATA_W +: DATA_W].
- wr_stall  in  1  register file cannot accept writes; blocks new grants.
- wr_en  out  1  register-file write enable (registered).
- wr_num  out  ADDR_W  register-file write index (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- grant_id  out  clog2(NUM_REQ)  index of the requester that produced the current wr_* (registered).

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, wr_num=0, wr_data=0, grant_id=0, rr_ptr=0. While rst_n is low, req_ready=0.
- Grant (combinational):
  - Scan req_valid starting at rr_ptr, ascending, with wrap-around.
  - The first valid requester i wins and gets req_ready[i]=1; all others get 0.
  - At most one req_ready bit is high. req_ready never depends on the requester's own ready.
- No grant is issued when wr_stall=1 or no req_valid bit is set; req_ready=0 in that case.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. Requesters hold req_num/req_data stable while valid and not ready.
- Pointer: after a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds. This guarantees a continuously valid requester is granted within NUM_REQ cycles.
- Output register, updated every cycle:
  - On a transfer: wr_num <= req_num[i], wr_data <= req_data[i], grant_id <= i, wr_en <= (req_num[i] != 0).
  - With no transfer: wr_en <= 0; wr_num, wr_data and grant_id hold.
- Latency: a transfer at edge N produces wr_en high during cycle N+1, for exactly one cycle per transfer.
- x0 writes: accepted normally (ready asserted, pointer advances) but never drive wr_en=1.
- Single-requester case: back-to-back transfers from the same requester are allowed every cycle, because the pointer wraps back to it.
- wr_stall asserted: no new transfers start. Any write already registered still appears on wr_en the next cycle. The pointer is frozen.
- Reset mid-operation: in-flight registered writes are discarded (wr_en forced 0) and the pointer returns to 0.

Optional Feature:
- Macro: REGWR_SCOREBOARD_EN.
- When defined, the following ports and logic exist:
  - Ports: rsv_valid in 1, rsv_num in ADDR_W, busy out 32.
  - busy[r] is set on the edge where rsv_valid=1 and rsv_num=r (r != 0).
  - busy[r] is cleared on the edge where the output register loads a transfer with req_num=r.
  - Set and clear of the same r on the same edge: set wins.
  - busy[0] is always 0. busy resets to all zeros.
- When undefined: the rsv_valid, rsv_num and busy ports and the scoreboard flops are absent; everything else is identical.

Test Plan:
- Reset, then req_valid=3'b001, req_num[0]=7, req_data[0]=32'hDEADBEEF -> req_ready=3'b001 the same cycle; next cycle wr_en=1, wr_num=7, wr_data=32'hDEADBEEF, grant_id=0.
- req_valid=3'b111 held for 6 cycles after reset -> grants in order 0,1,2,0,1,2; wr_en high for 6 consecutive cycles; each grant_id matches the grant order.
- req_valid[1]=1 with req_num=0, data=32'h55 -> req_ready[1]=1; next cycle wr_en=0; rr_ptr advances to 2.
- req_valid=3'b110, wr_stall=1 for 3 cycles -> req_ready=0 and wr_en=0 throughout. After wr_stall falls, requester 1 is granted first.
- Transfer at edge N, then rst_n pulled low mid-cycle N+1 -> wr_en falls immediately (asynchronous). After rst_n rises, grant order restarts at requester 0.
- REGWR_SCOREBOARD_EN defined: rsv r5, then requester 2 writes r5 two cycles later -> busy[5] reads 1 until the transfer edge, then 0. Simultaneous rsv r5 and write r5 -> busy[5] stays 1.
